// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = in1 - in2 - bin, one bit per clock,
// LSB first, under a start/busy/done handshake with registered outputs.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  function automatic logic diff_bit(input logic x, input logic y, input logic b);
    return x ^ y ^ b;
  endfunction

  // Borrow out of one bit position: x < y + b.
  function automatic logic borrow_bit(input logic x, input logic y, input logic b);
    return (~x & y) | (~(x ^ y) & b);
  endfunction

  always_comb begin
    d_bit    = diff_bit(a_sr[0], b_sr[0], br);
    br_next  = borrow_bit(a_sr[0], b_sr[0], br);
    res_next = {d_bit, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= in1;
            b_sr   <= in2;
            br     <= bin;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Operands drain LSB first; result bits enter at the MSB so the
          // WIDTH-th bit lands the result fully aligned.
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          res_sr <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff  <= res_next;
            bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against a plain-arithmetic
// reference: {0,in1} - {0,in2} - bin, borrow taken from the extra top bit.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic b);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b};
  endfunction

  // Called at a falling edge: request one operation, accepted on the next rising edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    in1   = x;
    in2   = y;
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, checking that the previous result holds meanwhile.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      chk("hold_diff", diff, held_diff);
      chk("hold_bout", bout, held_bout);
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) chk("done_timeout", cyc, W);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic b);
    logic [W:0] r;
    r = ref_sub(x, y, b);
    chk({tag, "_diff"}, diff, r[W-1:0]);
    chk({tag, "_bout"}, bout, r[W]);
    chk({tag, "_busy_low"}, busy, 0);
    held_diff = r[W-1:0];
    held_bout = r[W];
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic b);
    int cyc;
    launch(x, y, b);
    chk({tag, "_busy"}, busy, 1);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, W);
    check_result(tag, x, y, b);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;
    logic [W-1:0] rx, ry;
    logic rb;

    // Asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    full_op("basic1", 8'd8, 8'd3, 1'b0);
    full_op("basic2", 8'd9, 8'd3, 1'b1);
    full_op("wrap", 8'd0, 8'd1, 1'b0);
    full_op("inverse_add", 8'd45, 8'd100, 1'b1);

    // Second start mid-run must be ignored
    launch(8'd8, 8'd3, 1'b0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (i == 2) begin
        in1   = 8'd77;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    chk("ignore_busy_cycles", busy_cnt, W);
    chk("ignore_done_pulses", done_cnt, 1);
    check_result("ignore", 8'd8, 8'd3, 1'b0);

    // Back-to-back: start asserted in the done cycle
    launch(8'd200, 8'd50, 1'b0);
    wait_done(cyc);
    chk("b2b_first_latency", cyc, W);
    check_result("b2b_first", 8'd200, 8'd50, 1'b0);
    launch(8'd255, 8'd255, 1'b1);
    chk("b2b_second_busy", busy, 1);
    wait_done(cyc);
    chk("b2b_second_latency", cyc, W);
    check_result("b2b_second", 8'd255, 8'd255, 1'b1);
    @(negedge clk);

    // Reset during RUN aborts without a done pulse
    launch(8'd10, 8'd20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);
    held_diff = '0;
    held_bout = 1'b0;
    full_op("after_abort", 8'd10, 8'd20, 1'b0);

    // Random operands, with inputs scrambled after capture
    for (int n = 0; n < 24; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rb = 1'($urandom);
      launch(rx, ry, rb);
      in1 = W'($urandom);
      in2 = W'($urandom);
      bin = 1'($urandom);
      wait_done(cyc);
      chk("rand_latency", cyc, W);
      check_result("rand", rx, ry, rb);
      if (n % 2 == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
